// File: rtl/fcs32_append_8.sv
// Byte-wide Ethernet FCS inserter: forwards a sof/eof delimited payload, zero-pads
// short frames up to MIN_LEN and appends the 4-byte CRC-32 FCS behind a single output register.
module fcs32_append_8 #(
    parameter int unsigned MIN_LEN = 60,
    parameter int unsigned CNT_W   = 16
) (
    input  logic       pclk_i,
    input  logic       prst_n_i,
    input  logic [7:0] data_i,
    input  logic       val_i,
    input  logic       sof_i,
    input  logic       eof_i,
    output logic       rdy_o,
    output logic [7:0] data_o,
    output logic       val_o,
    output logic       sof_o,
    output logic       eof_o,
    input  logic       rdy_i,
    output logic       err_o
);

    typedef enum logic [1:0] {S_IDLE, S_PASS, S_PAD, S_FCS} state_t;

    // Reflected CRC-32 (poly 0xEDB88320), one byte LSB first.
    function automatic logic [31:0] fcs32_8(input logic [7:0] d, input logic [31:0] c);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int unsigned i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // Final inversion, byte-swapped so f[31:24] is the first FCS byte on the wire.
    function automatic logic [31:0] fcs32_brev(input logic [31:0] c);
        logic [31:0] f;
        f = ~c;
        return {f[7:0], f[15:8], f[23:16], f[31:24]};
    endfunction

    state_t           r_state, w_state_nx;
    logic [31:0]      r_crc, w_crc_nx;
    logic [31:0]      r_fcs, w_fcs_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [1:0]       r_idx, w_idx_nx;
    logic [7:0]       r_data, w_data_nx;
    logic             r_val, w_val_nx;
    logic             r_sof, w_sof_nx;
    logic             r_eof, w_eof_nx;
    logic             r_err, w_err_nx;
    logic             r_run;

    logic             w_load;
    logic             w_acc;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_inc_lt_min;
    logic [31:0]      w_crc_start;
    logic [31:0]      w_crc_pass;
    logic [31:0]      w_crc_pad;
    logic [7:0]       w_fcs_byte;

    assign w_load       = !r_val || rdy_i;
    // r_run keeps rdy_o low while reset is held and for the first clock after release.
    assign rdy_o        = r_run && ((r_state == S_IDLE) || (r_state == S_PASS)) && w_load;
    assign w_acc        = val_i && rdy_o;
    assign w_cnt_inc    = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    assign w_inc_lt_min = (32'(w_cnt_inc) < MIN_LEN);
    assign w_crc_start  = fcs32_8(data_i, '1);
    assign w_crc_pass   = fcs32_8(data_i, r_crc);
    assign w_crc_pad    = fcs32_8(8'h00, r_crc);

    always_comb begin
        w_fcs_byte = r_fcs[7:0];
        case (r_idx)
            2'd0:    w_fcs_byte = r_fcs[31:24];
            2'd1:    w_fcs_byte = r_fcs[23:16];
            2'd2:    w_fcs_byte = r_fcs[15:8];
            default: w_fcs_byte = r_fcs[7:0];
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        w_crc_nx   = r_crc;
        w_fcs_nx   = r_fcs;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        w_data_nx  = r_data;
        w_val_nx   = r_val;
        w_sof_nx   = r_sof;
        w_eof_nx   = r_eof;
        w_err_nx   = 1'b0;
        if (w_load) begin
            w_val_nx = 1'b0;
            w_sof_nx = 1'b0;
            w_eof_nx = 1'b0;
        end
        case (r_state)
            S_IDLE, S_PASS: begin
                if (w_acc && sof_i) begin
                    // A sof inside PASS abandons the open frame and restarts here.
                    w_err_nx  = (r_state == S_PASS);
                    w_data_nx = data_i;
                    w_val_nx  = 1'b1;
                    w_sof_nx  = 1'b1;
                    w_crc_nx  = w_crc_start;
                    w_cnt_nx  = CNT_W'(1);
                    w_idx_nx  = 2'd0;
                    if (!eof_i) begin
                        w_state_nx = S_PASS;
                    end else if (MIN_LEN > 1) begin
                        w_state_nx = S_PAD;
                    end else begin
                        w_state_nx = S_FCS;
                        w_fcs_nx   = fcs32_brev(w_crc_start);
                    end
                end else if (w_acc && (r_state == S_IDLE)) begin
                    w_err_nx = 1'b1;
                end else if (w_acc) begin
                    w_data_nx = data_i;
                    w_val_nx  = 1'b1;
                    w_crc_nx  = w_crc_pass;
                    w_cnt_nx  = w_cnt_inc;
                    w_idx_nx  = 2'd0;
                    if (eof_i && w_inc_lt_min) begin
                        w_state_nx = S_PAD;
                    end else if (eof_i) begin
                        w_state_nx = S_FCS;
                        w_fcs_nx   = fcs32_brev(w_crc_pass);
                    end
                end
            end
            S_PAD: begin
                if (w_load) begin
                    w_data_nx = 8'h00;
                    w_val_nx  = 1'b1;
                    w_crc_nx  = w_crc_pad;
                    w_cnt_nx  = w_cnt_inc;
                    if (!w_inc_lt_min) begin
                        w_state_nx = S_FCS;
                        w_fcs_nx   = fcs32_brev(w_crc_pad);
                        w_idx_nx   = 2'd0;
                    end
                end
            end
            default: begin
                if (w_load) begin
                    w_data_nx = w_fcs_byte;
                    w_val_nx  = 1'b1;
                    w_eof_nx  = (r_idx == 2'd3);
                    w_idx_nx  = r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        w_state_nx = S_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) begin
            r_state <= S_IDLE;
            r_crc   <= '1;
            r_fcs   <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_val   <= 1'b0;
            r_sof   <= 1'b0;
            r_eof   <= 1'b0;
            r_err   <= 1'b0;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_crc   <= w_crc_nx;
            r_fcs   <= w_fcs_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_data  <= w_data_nx;
            r_val   <= w_val_nx;
            r_sof   <= w_sof_nx;
            r_eof   <= w_eof_nx;
            r_err   <= w_err_nx;
            r_run   <= 1'b1;
        end
    end

    assign data_o = r_data;
    assign val_o  = r_val;
    assign sof_o  = r_sof;
    assign eof_o  = r_eof;
    assign err_o  = r_err;

endmodule

// File: tb/tb_fcs32_append_8.sv
// Bench for fcs32_append_8: two instances (MIN_LEN=0 and MIN_LEN=60) driven from one
// stimulus path, outputs compared against a bit-serial CRC-32 frame model.
module tb_fcs32_append_8;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_i;
    logic       val_i, sof_i, eof_i, rdy_i;
    logic       sel;
    int         rdy_mode;

    logic       val_a, val_b;
    logic       rdy_o_a, val_o_a, sof_o_a, eof_o_a, err_o_a;
    logic       rdy_o_b, val_o_b, sof_o_b, eof_o_b, err_o_b;
    logic [7:0] data_o_a, data_o_b;
    logic       w_rdy_o, w_val_o, w_sof_o, w_eof_o, w_err_o;
    logic [7:0] w_data_o;

    always #5 clk = ~clk;

    assign val_a    = val_i & ~sel;
    assign val_b    = val_i & sel;
    assign w_rdy_o  = sel ? rdy_o_b  : rdy_o_a;
    assign w_val_o  = sel ? val_o_b  : val_o_a;
    assign w_sof_o  = sel ? sof_o_b  : sof_o_a;
    assign w_eof_o  = sel ? eof_o_b  : eof_o_a;
    assign w_err_o  = sel ? err_o_b  : err_o_a;
    assign w_data_o = sel ? data_o_b : data_o_a;

    fcs32_append_8 #(.MIN_LEN(0), .CNT_W(16)) u_dut0 (
        .pclk_i(clk), .prst_n_i(rst_n), .data_i(data_i), .val_i(val_a),
        .sof_i(sof_i), .eof_i(eof_i), .rdy_o(rdy_o_a), .data_o(data_o_a),
        .val_o(val_o_a), .sof_o(sof_o_a), .eof_o(eof_o_a), .rdy_i(rdy_i),
        .err_o(err_o_a)
    );

    fcs32_append_8 #(.MIN_LEN(60), .CNT_W(16)) u_dut60 (
        .pclk_i(clk), .prst_n_i(rst_n), .data_i(data_i), .val_i(val_b),
        .sof_i(sof_i), .eof_i(eof_i), .rdy_o(rdy_o_b), .data_o(data_o_b),
        .val_o(val_o_b), .sof_o(sof_o_b), .eof_o(eof_o_b), .rdy_i(rdy_i),
        .err_o(err_o_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Downstream ready: 0 = always ready, 1 = random 50%, 2 = stalled.
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1)      rdy_i = 1'($urandom_range(0, 1));
        else if (rdy_mode == 2) rdy_i = 1'b0;
        else                    rdy_i = 1'b1;
    end

    logic [9:0] rx_q[$];
    logic [9:0] exp_q[$];
    int         err_pulses = 0;
    logic       prev_stall = 1'b0;
    logic [9:0] prev_out   = '0;

    always @(negedge clk) begin
        if (w_err_o) err_pulses++;
        if (prev_stall) check("hold", 32'({w_sof_o, w_eof_o, w_data_o}), 32'(prev_out));
        if (w_val_o && rdy_i) rx_q.push_back({w_sof_o, w_eof_o, w_data_o});
        prev_stall = rst_n & w_val_o & ~rdy_i;
        prev_out   = {w_sof_o, w_eof_o, w_data_o};
    end

    // Expected wire image: payload, zero pad to min_len, then ~CRC least-significant byte first.
    task automatic model(input bq_t p, input int unsigned min_len);
        bq_t         q;
        logic [31:0] c;
        logic        fb;
        q = p;
        while (q.size() < min_len) q.push_back(8'h00);
        c = '1;
        foreach (q[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ q[i][b];
                c  = (c >> 1) ^ (fb ? 32'hEDB88320 : 32'h0);
            end
        end
        c = ~c;
        for (int k = 0; k < 4; k++) q.push_back(c[8*k +: 8]);
        foreach (q[i]) exp_q.push_back({(i == 0), (i == q.size() - 1), q[i]});
    endtask

    // Called just after a rising edge; returns just after the edge that took the byte.
    task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
        logic ok;
        ok     = 1'b0;
        data_i = d; sof_i = s; eof_i = e; val_i = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            ok = w_rdy_o;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) check("accept_timeout", 32'(ok), 32'd1);
        val_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0;
    endtask

    task automatic send_frame(input bq_t p);
        foreach (p[i]) send_byte(p[i], (i == 0), (i == p.size() - 1));
    endtask

    task automatic finish(input string tag, input int exp_err);
        for (int n = 0; n < 5000 && rx_q.size() < exp_q.size(); n++) @(negedge clk);
        repeat (4) @(negedge clk);
        check({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check({tag, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
        check({tag, "_err"}, 32'(err_pulses), 32'(exp_err));
        rx_q.delete(); exp_q.delete(); err_pulses = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_123(input string tag);
        bq_t p;
        for (int i = 0; i < 9; i++) p.push_back(8'(8'h31 + i));
        model(p, 0);
        send_frame(p);
        for (int n = 0; n < 500 && rx_q.size() < 13; n++) @(negedge clk);
        if (rx_q.size() >= 13)
            check({tag, "_fcs"}, {rx_q[9][7:0], rx_q[10][7:0], rx_q[11][7:0], rx_q[12][7:0]},
                  32'h2639F4CB);
        else
            check({tag, "_fcs_count"}, 32'(rx_q.size()), 32'd13);
        finish(tag, 0);
    endtask

    task automatic rand_frame(input int unsigned len, output bq_t p);
        p.delete();
        for (int unsigned i = 0; i < len; i++) p.push_back(8'($urandom));
    endtask

    initial begin
        bq_t p;
        rst_n = 1'b0; data_i = '0; val_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0;
        rdy_i = 1'b1; sel = 1'b0; rdy_mode = 0;
        @(negedge clk);
        check("rst_val",  32'({val_o_a, val_o_b}), 32'd0);
        check("rst_rdy",  32'({rdy_o_a, rdy_o_b}), 32'd0);
        check("rst_data", 32'({data_o_a, data_o_b}), 32'd0);
        check("rst_flags", 32'({sof_o_a, eof_o_a, err_o_a, sof_o_b, eof_o_b, err_o_b}), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        test_123("t1");

        sel = 1'b1;
        p.delete(); p.push_back(8'hAA);
        model(p, 60);
        send_frame(p);
        finish("t2", 0);

        sel = 1'b0; rdy_mode = 1;
        test_123("t3");

        send_byte(8'h55, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        check("t4_noout", 32'(rx_q.size()), 32'd0);
        check("t4_err", 32'(err_pulses), 32'd1);
        err_pulses = 0;
        @(posedge clk); #1;
        rand_frame(7, p); model(p, 0); send_frame(p);
        finish("t4", 0);

        sel = 1'b1;
        rand_frame(3, p);
        exp_q.push_back({2'b10, p[0]}); exp_q.push_back({2'b00, p[1]}); exp_q.push_back({2'b00, p[2]});
        foreach (p[i]) send_byte(p[i], (i == 0), 1'b0);
        rand_frame(70, p); model(p, 60); send_frame(p);
        finish("t5", 1);

        sel = 1'b0; rdy_mode = 0;
        for (int i = 0; i < 9; i++) p[i] = 8'(8'h31 + i);
        p = p[0:8];
        send_frame(p);
        for (int n = 0; n < 500 && rx_q.size() < 11; n++) @(negedge clk);
        check("t6_pre", 32'(rx_q.size()), 32'd11);
        rdy_mode = 2;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("t6_val", 32'(val_o_a), 32'd0);
        check("t6_rdy", 32'(rdy_o_a), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; rdy_mode = 0;
        rx_q.delete(); exp_q.delete(); err_pulses = 0;
        @(posedge clk); #1;
        test_123("t6_after");

        rdy_mode = 1;
        for (int k = 0; k < 6; k++) begin
            sel = k[0];
            rand_frame($urandom_range(1, 80), p);
            model(p, sel ? 60 : 0);
            send_frame(p);
            rand_frame($urandom_range(1, 80), p);
            model(p, sel ? 60 : 0);
            send_frame(p);
            finish("rnd", 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
